// File: rtl/queue_pkg.sv
// rtl/queue_pkg.sv - shared widths and FSM encoding for the circular queue controller
package queue_pkg;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } state_e;

endpackage : queue_pkg

// File: rtl/queue_ctrl_cmp.sv
// rtl/queue_ctrl_cmp.sv - 10-bit equality comparator on next head/tail addresses
module queue_ctrl_cmp
  import queue_pkg::*;
(
  input  logic [ADDR_W-1:0] a_i,
  input  logic [ADDR_W-1:0] b_i,
  output logic              eq_o
);

  logic [ADDR_W-1:0] diff;

  // Subtract chain followed by a NOR: equal addresses give a zero difference
  always_comb begin
    diff = a_i - b_i;
    eq_o = ~|diff;
  end

endmodule : queue_ctrl_cmp

// File: rtl/queue_ctrl.sv
// rtl/queue_ctrl.sv - pointer, occupancy and status controller for the 1024-entry queue
module queue_ctrl
  import queue_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              wr_req_i,
  input  logic              rd_req_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              wr_ack_o,
  output logic              rd_ack_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  state_e            state_q;
  logic [ADDR_W:0]   wr_ptr_q, rd_ptr_q, count_q;
  logic [ADDR_W:0]   wr_ptr_d, rd_ptr_d, count_d;
  logic              wr_en_q, rd_en_q, ovf_q, unf_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
  logic              wr_acc, rd_acc, eq, empty_nxt, full_nxt;

  // Accept decisions and next pointers; the flags come straight from the state register
  always_comb begin
    wr_acc    = wr_req_i & ~full_o;
    rd_acc    = rd_req_i & ~empty_o;
    wr_ptr_d  = wr_ptr_q + {{ADDR_W{1'b0}}, wr_acc};
    rd_ptr_d  = rd_ptr_q + {{ADDR_W{1'b0}}, rd_acc};
    count_d   = wr_ptr_d - rd_ptr_d;
    empty_nxt = eq & (wr_ptr_d[ADDR_W] == rd_ptr_d[ADDR_W]);
    full_nxt  = eq & (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
  end

  queue_ctrl_cmp u_cmp (
    .a_i  (wr_ptr_d[ADDR_W-1:0]),
    .b_i  (rd_ptr_d[ADDR_W-1:0]),
    .eq_o (eq)
  );

  // Occupancy FSM with pointers and all registered strobes/pulses; flush overrides everything
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= EMPTY;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else if (flush_i) begin
      state_q   <= EMPTY;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_en_q  <= wr_acc;
      rd_en_q  <= rd_acc;
      ovf_q    <= wr_req_i & full_o;
      unf_q    <= rd_req_i & empty_o;
      if (wr_acc) wr_addr_q <= wr_ptr_q[ADDR_W-1:0];
      if (rd_acc) rd_addr_q <= rd_ptr_q[ADDR_W-1:0];
      case (state_q)
        EMPTY:   if (wr_acc) state_q <= ACTIVE;
        ACTIVE:  if (empty_nxt) state_q <= EMPTY;
                 else if (full_nxt) state_q <= FULL;
        FULL:    if (rd_acc) state_q <= ACTIVE;
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_ack_o    = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign rd_en_o     = rd_en_q;
  assign rd_ack_o    = rd_en_q;
  assign rd_addr_o   = rd_addr_q;
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign empty_o     = (state_q == EMPTY);
  assign full_o      = (state_q == FULL);

endmodule : queue_ctrl

// File: doc/queue_ctrl.md
# queue_ctrl

Pointer and status controller for the 1024-entry circular queue. It accepts write/read requests, issues registered RAM write/read strobes and addresses, and tracks occupancy through a three-state FSM. Full and empty are resolved by the 10-bit equality Comparator on the next head/tail addresses plus a wrap bit. It sits between the requesting logic and the queue storage RAM, which holds no control logic of its own.

## Interface
- ADDR_W, 10, address width; fixed at 10 by the Comparator width.
- DEPTH, 1024, entries; equals 2**ADDR_W.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous clear of pointers and status; highest priority.
- wr_req_i  in  1  write request; level, sampled each cycle.
- rd_req_i  in  1  read request; level, sampled each cycle.
- wr_en_o  out  1  RAM write strobe; registered.
- wr_addr_o  out  10  RAM write address; registered.
- rd_en_o  out  1  RAM read strobe; registered.
- rd_addr_o  out  10  RAM read address; registered.
- wr_ack_o  out  1  one-cycle pulse, coincident with wr_en_o.
- rd_ack_o  out  1  one-cycle pulse, coincident with rd_en_o.
- full_o  out  1  registered; 1 when 1024 entries are held.
- empty_o  out  1  registered; 1 when 0 entries are held.
- count_o  out  11  registered occupancy, 0..1024.
- overflow_o  out  1  one-cycle pulse; write request refused because the queue is full.
- underflow_o  out  1  one-cycle pulse; read request refused because the queue is empty.

## Operation
- Pointers: wr_ptr and rd_ptr are 11 bits each. Bit 10 is the wrap bit; bits 9:0 are the RAM address.
- Accept rules (evaluated against the registered flags):
  - wr_acc = wr_req_i & ~full_o
  - rd_acc = rd_req_i & ~empty_o
- Next pointers: each accepted operation increments its pointer by 1, modulo 2048. Address 1023 wraps to 0 and toggles the wrap bit.
- Comparator inputs: A = wr_ptr_nxt[9:0], B = rd_ptr_nxt[9:0]. Its output is eq.
  - empty_nxt = eq & (wrap bits equal)
  - full_nxt = eq & (wrap bits differ)
- Occupancy: count_nxt = wr_ptr_nxt - rd_ptr_nxt, modulo 2048.
- FSM states: EMPTY, ACTIVE, FULL. Reset state is EMPTY.
  - EMPTY -> ACTIVE on wr_acc.
  - ACTIVE -> EMPTY when empty_nxt; ACTIVE -> FULL when full_nxt.
  - FULL -> ACTIVE on rd_acc.
  - Any state -> EMPTY on flush_i.
- Flag outputs: empty_o = (state == EMPTY); full_o = (state == FULL).
- Simultaneous wr_acc and rd_acc:
  - Both pointers advance; count_o is unchanged; the state is unchanged.
  - In EMPTY only the write is accepted; the read raises underflow_o.
  - In FULL only the read is accepted; the write raises overflow_o.
- Flush: pointers go to 0, count_o to 0, state to EMPTY. No strobes or acks are issued that cycle. Requests in the flush cycle are dropped without an overflow or underflow pulse.
- Reset values: all outputs 0, except empty_o = 1. Pointers are 0.
- Reset asserted mid-operation: immediate return to the reset values. Any in-flight strobe is cancelled.

## Timing
- Request in cycle N leads to wr_en_o/wr_addr_o/wr_ack_o (or the read equivalents) in cycle N+1.
  - The address presented is the pre-increment pointer.
- Flags, count_o and state update at the same edge as the strobes. Every decision uses exact occupancy, with no stale window.
- Back-to-back requests give 1 operation per cycle per port, sustained.
- RAM read data timing is owned by the RAM. This block only guarantees rd_addr_o is valid while rd_en_o is high.
- overflow_o and underflow_o are registered and appear in cycle N+1.
- The Comparator path (pointer increment, then the 10-bit subtract chain, then the NOR) is the critical path. It must close within one clk_i period.

## Structure
- Shared package queue_pkg holds:
  - ADDR_W and DEPTH.
  - The state encoding constants: EMPTY = 2'd0, ACTIVE = 2'd1, FULL = 2'd2.
- Instantiate the existing Comparator once. It is the only sub-module.
- queue_ctrl owns the remaining logic: pointer registers, incrementers, count subtractor, FSM, output registers.

## Test plan
- Reset, then 3 writes followed by 3 reads:
  - wr_addr_o = 0, 1, 2; rd_addr_o = 0, 1, 2.
  - count_o goes 1, 2, 3, 2, 1, 0.
  - empty_o returns to 1 on the edge after the 3rd read.
- Fill to capacity with 1024 consecutive writes:
  - full_o = 1 and count_o = 1024 after the last write.
  - A 1025th write pulses overflow_o, with no wr_en_o and no pointer change.
- Wrap-around with continuous simultaneous read and write at count_o = 512 for 2000 cycles:
  - count_o stays at 512.
  - Addresses wrap from 1023 to 0.
  - full_o and empty_o are never set.
- Read while empty after reset:
  - underflow_o pulses in cycle N+1; rd_en_o stays 0.
  - Simultaneous write and read while empty: only the write is accepted, count_o = 1.
- Flush at count_o = 700 together with wr_req_i:
  - Next cycle count_o = 0, empty_o = 1, no wr_ack_o.
  - The next write uses wr_addr_o = 0.
- Assert rst_i asynchronously mid-cycle while full:
  - All outputs go to their reset values immediately, without waiting for a clock edge (empty_o = 1, full_o = 0).
  - The first write after release uses address 0.
